capture_ctrl: RTL and testbench

- Trigger/capture sequencer for one scope channel. It sits between the ADC channel and the per-channel sample buffer, and issues buffer write strobes and addresses.
- Captures a frame of DEPTH samples: PRE samples before a level crossing, then the trigger sample, then the post-trigger samples. Reports the trigger address so the display reads a stable, trigger-aligned frame.
- Supports auto, normal and single-shot modes, plus a hold freeze driven from the controls block.

---
 rtl/capture_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - trigger/capture sequencer for one scope channel
// Optional hysteresis-qualified trigger: define TRIG_HYST_EN.
module capture_ctrl #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 640,
  parameter int ADDR_W  = 10,
  parameter int PRE     = 320,
  parameter int AUTO_TO = 4096,
  parameter int HYST    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        mode,
  input  logic              hold,
  input  logic              rearm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              frame_done,
  output logic              forced,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = $clog2(AUTO_TO + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE - 2);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TO);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

  // Illegal parameter sets elaborate this empty marker block.
  if (PRE < 1 || PRE > DEPTH - 2 || (2 ** ADDR_W) < DEPTH || HYST < 0) begin : g_bad_params
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_post_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_valid;
  logic [ADDR_W-1:0] r_trig_pend;
  logic              r_forced_pend;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_frame_done;
  logic              r_forced;

  logic              w_capture;
  logic              w_accept;
  logic              w_cross;
  logic              w_trig;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_ptr_next;

  assign w_capture  = (r_state == S_PRETRIG) || (r_state == S_ARMED) || (r_state == S_POST);
  // A rearm pulse discards the coincident sample so the restart is clean.
  assign w_accept   = sample_en && !hold && !rearm && w_capture;
  assign w_ptr_next = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_ONE;
  assign w_cross    = trig_slope
                    ? (r_prev_valid && (r_prev > trig_level) && (sample_data <= trig_level))
                    : (r_prev_valid && (r_prev < trig_level) && (sample_data >= trig_level));
  assign w_timeout  = (mode == 2'b00) && (r_to_cnt >= TO_LAST);

`ifdef TRIG_HYST_EN
  localparam logic [DATA_W:0] HYST_X = (DATA_W + 1)'(HYST);
  localparam logic [DATA_W:0] MAX_X  = {1'b0, {DATA_W{1'b1}}};

  logic              r_hyst_ok;
  logic [DATA_W:0]   w_lvl_x;
  logic [DATA_W:0]   w_lo_x;
  logic [DATA_W:0]   w_hi_x;
  logic              w_rearm_seen;

  // Band edges computed one bit wider so they clamp instead of wrapping.
  assign w_lvl_x      = {1'b0, trig_level};
  assign w_lo_x       = (w_lvl_x >= HYST_X) ? (w_lvl_x - HYST_X) : '0;
  assign w_hi_x       = ((w_lvl_x + HYST_X) > MAX_X) ? MAX_X : (w_lvl_x + HYST_X);
  assign w_rearm_seen = trig_slope ? ({1'b0, sample_data} >= w_hi_x)
                                   : ({1'b0, sample_data} <= w_lo_x);
  assign w_trig       = w_cross && r_hyst_ok;
`else
  assign w_trig       = w_cross;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_pre_cnt     <= '0;
      r_post_cnt    <= '0;
      r_to_cnt      <= '0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_trig_pend   <= '0;
      r_forced_pend <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_trig_addr   <= '0;
      r_frame_done  <= 1'b0;
      r_forced      <= 1'b0;
`ifdef TRIG_HYST_EN
      r_hyst_ok     <= 1'b0;
`endif
    end else begin
      r_wr_en      <= w_accept;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_wr_data    <= sample_data;
        r_wr_addr    <= r_ptr;
        r_ptr        <= w_ptr_next;
        r_prev       <= sample_data;
        r_prev_valid <= 1'b1;
      end
      if (rearm) begin
        r_state      <= S_PRETRIG;
        r_pre_cnt    <= '0;
        r_post_cnt   <= '0;
        r_to_cnt     <= '0;
        r_prev_valid <= 1'b0;
`ifdef TRIG_HYST_EN
        r_hyst_ok    <= 1'b0;
`endif
      end else if (!hold) begin
        case (r_state)
          S_IDLE: begin
            r_state      <= S_PRETRIG;
            r_pre_cnt    <= '0;
            r_prev_valid <= 1'b0;
          end
          S_PRETRIG: begin
            if (w_accept) begin
              r_pre_cnt <= r_pre_cnt + CNT_ONE;
              if (r_pre_cnt == PRE_LAST) begin
                r_state  <= S_ARMED;
                r_to_cnt <= '0;
`ifdef TRIG_HYST_EN
                r_hyst_ok <= 1'b0;
`endif
              end
            end
          end
          S_ARMED: begin
            if (w_accept) begin
              if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + TO_ONE;
`ifdef TRIG_HYST_EN
              if (w_rearm_seen) r_hyst_ok <= 1'b1;
`endif
              if (w_trig || w_timeout) begin
                r_trig_pend   <= r_ptr;
                r_forced_pend <= !w_trig;
                r_post_cnt    <= '0;
                r_state       <= S_POST;
              end
            end
          end
          S_POST: begin
            if (w_accept) begin
              r_post_cnt <= r_post_cnt + CNT_ONE;
              if (r_post_cnt == POST_LAST) begin
                r_state      <= S_DONE;
                r_trig_addr  <= r_trig_pend;
                r_forced     <= r_forced_pend;
                r_frame_done <= 1'b1;
              end
            end
          end
          S_DONE: begin
            // Single-shot parks here until rearm; other modes restart on the next strobe.
            if (sample_en && (mode != 2'b10)) begin
              r_state      <= S_PRETRIG;
              r_pre_cnt    <= '0;
              r_prev_valid <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign trig_addr  = r_trig_addr;
  assign frame_done = r_frame_done;
  assign forced     = r_forced;
  assign state      = r_state;

endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl (DEPTH=16, PRE=4, AUTO_TO=8)
module tb_capture_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] sample_data = '0;
  logic [11:0] trig_level = '0;
  logic        trig_slope = 1'b0;
  logic [1:0]  mode = 2'b01;
  logic        hold = 1'b0;
  logic        rearm = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  trig_addr;
  logic        frame_done;
  logic        forced;
  logic [2:0]  state;

  capture_ctrl #(
    .DATA_W(12), .DEPTH(16), .ADDR_W(4), .PRE(4), .AUTO_TO(8), .HYST(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sample_en(sample_en), .sample_data(sample_data),
    .trig_level(trig_level), .trig_slope(trig_slope), .mode(mode), .hold(hold), .rearm(rearm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
    .frame_done(frame_done), .forced(forced), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int taddr; int frc; } fr_t;
  wr_t wq[$];
  fr_t fq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_wr     = 0;
  int  n_frame  = 0;

`ifdef TRIG_HYST_EN
  localparam int HT_IDX = 9;
`else
  localparam int HT_IDX = 5;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (wr_en) begin
        wr_t w;
        n_wr++;
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0d, no write expected", wr_addr, wr_data);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", int'(wr_addr), w.addr);
          chk("wr_data", int'(wr_data), w.data);
        end
      end
      if (frame_done) begin
        fr_t f;
        n_frame++;
        if (fq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_done: trig_addr %0d, none expected", trig_addr);
        end else begin
          f = fq.pop_front();
          chk("trig_addr", int'(trig_addr), f.taddr);
          chk("forced", int'(forced), f.frc);
        end
      end
    end
  end

  task automatic sample(input int d);
    @(posedge clock); #1;
    sample_en   = 1'b1;
    sample_data = 12'(d);
    @(posedge clock); #1;
    sample_en   = 1'b0;
  endtask

  task automatic expect_wr(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic expect_frame(input int ta, input int f);
    fr_t fr;
    fr.taddr = ta;
    fr.frc   = f;
    fq.push_back(fr);
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    sample_en = 1'b0; hold = 1'b0; rearm = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    n_wr = 0;
    n_frame = 0;
  endtask

  task automatic end_test(input string name, input int writes, input int frames);
    repeat (2) settle();
    chk({name, "_wq_empty"}, wq.size(), 0);
    chk({name, "_fq_empty"}, fq.size(), 0);
    chk({name, "_writes"}, n_wr, writes);
    chk({name, "_frames"}, n_frame, frames);
  endtask

  initial begin
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_forced", int'(forced), 0);

    // Normal, rising ramp: trigger on 600 at index 6, 4 pre + 3 armed + 11 post writes.
    do_reset();
    mode = 2'b01; trig_level = 12'd550; trig_slope = 1'b0;
    settle();
    chk("t1_pretrig", int'(state), 1);
    expect_frame(6, 0);
    for (int i = 0; i < 18; i++) begin
      expect_wr(i % 16, i * 100);
      sample(i * 100);
    end
    settle();
    chk("t1_done_state", int'(state), 4);
    sample(999);
    settle();
    chk("t1_done_exit", int'(state), 1);
    end_test("t1", 18, 1);

    // Auto, flat input: forced trigger on 8th armed sample (index 11).
    do_reset();
    mode = 2'b00; trig_level = 12'd500;
    expect_frame(11, 1);
    for (int i = 0; i < 23; i++) begin
      expect_wr(i % 16, 10);
      sample(10);
      if (i == 21) begin
        settle();
        chk("t2_no_early_frame", n_frame, 0);
      end
    end
    settle();
    chk("t2_frame_after_23", n_frame, 1);
    chk("t2_forced_out", int'(forced), 1);
    end_test("t2", 23, 1);

    // Single shot: DONE holds through 50 strobes, rearm restarts at pointer 2.
    do_reset();
    mode = 2'b10; trig_level = 12'd550;
    expect_frame(6, 0);
    for (int i = 0; i < 18; i++) begin
      expect_wr(i % 16, i * 100);
      sample(i * 100);
    end
    for (int i = 0; i < 50; i++) sample(1234);
    settle();
    chk("t3_done_persist", int'(state), 4);
    @(posedge clock); #1 rearm = 1'b1;
    @(posedge clock); #1 rearm = 1'b0;
    settle();
    chk("t3_rearm_state", int'(state), 1);
    chk("t3_trig_kept", int'(trig_addr), 6);
    expect_wr(2, 77);
    sample(77);
    end_test("t3", 19, 1);

    // Hold mid-POST for 20 strobes: frame still totals 16 writes.
    do_reset();
    mode = 2'b01; trig_level = 12'd500;
    expect_frame(4, 0);
    for (int i = 0; i < 4; i++) begin expect_wr(i, 0); sample(0); end
    expect_wr(4, 600);
    sample(600);
    for (int i = 5; i < 10; i++) begin expect_wr(i, 700 + i); sample(700 + i); end
    @(posedge clock); #1 hold = 1'b1;
    for (int i = 0; i < 20; i++) sample(4000);
    settle();
    chk("t4_hold_state", int'(state), 3);
    @(posedge clock); #1 hold = 1'b0;
    for (int i = 10; i < 15; i++) begin expect_wr(i, 700 + i); sample(700 + i); end
    settle();
    chk("t4_post_cnt_frozen", n_frame, 0);
    expect_wr(15, 715);
    sample(715);
    settle();
    chk("t4_frame_on_16th", n_frame, 1);
    end_test("t4", 16, 1);

    // Asynchronous reset while ARMED.
    do_reset();
    mode = 2'b01; trig_level = 12'd4000;
    for (int i = 0; i < 6; i++) begin expect_wr(i, 50 + i); sample(50 + i); end
    settle();
    chk("t5_armed", int'(state), 2);
    @(negedge clock); #1 reset_n = 1'b0;
    #1;
    chk("t5_state", int'(state), 0);
    chk("t5_wr_en", int'(wr_en), 0);
    chk("t5_wr_addr", int'(wr_addr), 0);
    chk("t5_wr_data", int'(wr_data), 0);
    chk("t5_trig_addr", int'(trig_addr), 0);
    chk("t5_forced", int'(forced), 0);
    end_test("t5", 6, 0);

    // Hysteresis sequence; without the option the first crossing (index 5) wins.
    do_reset();
    mode = 2'b01; trig_level = 12'd500; trig_slope = 1'b0;
    expect_frame(HT_IDX, 0);
    for (int i = 0; i < HT_IDX + 12; i++) begin
      int d;
      case (i)
        5, 7, 9: d = 505;
        8:       d = 480;
        default: d = (i < 10) ? 495 : 600;
      endcase
      expect_wr(i % 16, d);
      sample(d);
    end
    end_test("t6", HT_IDX + 12, 1);

    // Falling slope, equality on the trigger sample (300 at index 7).
    do_reset();
    mode = 2'b11; trig_level = 12'd300; trig_slope = 1'b1;
    expect_frame(7, 0);
    for (int i = 0; i < 19; i++) begin
      int d;
      d = (i < 10) ? 1000 - 100 * i : 0;
      expect_wr(i % 16, d);
      sample(d);
    end
    end_test("t7", 19, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
